// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port bundle for the fetch stage: req/gnt/rvalid handshake.
// The fetch stage takes the master side, the instruction memory the slave side.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: owns the PC, issues one imem request at a time, presents {pc, insn} to IF/ID.
// Optional feature macro IF_PERF_CNT_EN adds fetched/bubble performance counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pc_write,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    if_fetch_stage_if.master    imem,
    output logic [31:0]         pc_out,
    output logic [31:0]         instruction_out,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubble,
`endif
    output logic                if_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_insn_q, hold_insn_d;

    logic [31:0] redirect_tgt_s;
    logic        live_rsp_s;
    logic        unused_redirect_lsb_s;

    assign redirect_tgt_s        = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb_s = ^redirect_pc[1:0];
    // A response that is neither stale nor overtaken by a redirect this cycle.
    assign live_rsp_s = (state_q == S_WAIT) && imem.imem_rvalid && !discard_q && !redirect_valid;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (imem.imem_gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (!imem.imem_rvalid) begin
                    state_d = S_WAIT;
                end else if (discard_q || redirect_valid || pc_write) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || pc_write) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'h0000_0000;
            discard_q   <= 1'b0;
            hold_pc_q   <= 32'h0000_0000;
            hold_insn_q <= 32'h0000_0000;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            discard_q   <= discard_d;
            hold_pc_q   <= hold_pc_d;
            hold_insn_q <= hold_insn_d;
        end
    end

    // Datapath next values; redirect overrides any sequential PC advance
    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        discard_d   = discard_q;
        hold_pc_d   = hold_pc_q;
        hold_insn_d = hold_insn_q;
        case (state_q)
            S_REQ: begin
                if (imem.imem_gnt) begin
                    req_pc_d  = pc_q;
                    discard_d = redirect_valid;
                end else begin
                    discard_d = discard_q;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    discard_d = 1'b0;
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
                if (live_rsp_s && pc_write) begin
                    pc_d = req_pc_q + 32'd4;
                end else if (live_rsp_s) begin
                    hold_pc_d   = req_pc_q;
                    hold_insn_d = imem.imem_rdata;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_HOLD: begin
                if (pc_write) begin
                    pc_d = hold_pc_q + 32'd4;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                discard_d = 1'b0;
            end
        endcase
        if (redirect_valid) begin
            pc_d = redirect_tgt_s;
        end else begin
            pc_d = pc_d;
        end
    end

    // Output decode; imem_req is gated by reset so the port is quiet while held in reset
    always_comb begin
        imem.imem_req   = 1'b0;
        imem.imem_addr  = pc_q;
        if_valid        = 1'b0;
        pc_out          = pc_q;
        instruction_out = NOP_INSN;
        case (state_q)
            S_REQ: begin
                imem.imem_req = resetn;
            end
            S_WAIT: begin
                if (live_rsp_s && resetn) begin
                    if_valid        = 1'b1;
                    pc_out          = req_pc_q;
                    instruction_out = imem.imem_rdata;
                end else begin
                    if_valid = 1'b0;
                end
            end
            S_HOLD: begin
                if (!redirect_valid && resetn) begin
                    if_valid        = 1'b1;
                    pc_out          = hold_pc_q;
                    instruction_out = hold_insn_q;
                end else begin
                    if_valid = 1'b0;
                end
            end
            default: begin
                imem.imem_req = 1'b0;
            end
        endcase
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubble_q;

    // Retired-fetch and bubble counters, both advance only when IF/ID accepts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_bubble_q  <= 32'h0000_0000;
        end else if (pc_write) begin
            if (if_valid) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end else begin
                perf_bubble_q  <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubble  = perf_bubble_q;
`endif

endmodule
